// File: rtl/pc_seq_unit.sv
// Next-PC generator owning the PC, trap entry/return (mepc), RUN/HANDLER/HALT
// state machine and a retired-instruction counter.
module pc_seq_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h0,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h100,
  parameter int              IALIGN   = 32,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  aluout,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  mepc,
  output logic             misalign,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;
  localparam logic [2:0] NPC_TRAP   = 3'b110;
  localparam logic [2:0] NPC_MRET   = 3'b111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] mepc_n;
  logic            is_trap;
  logic            is_mret;
  logic            trap_req;
  logic            commit;

  always_comb begin
    target = pc + XLEN'(4);
    case (npc_op)
      NPC_BRANCH: target = pc + imm;
      NPC_JUMP:   target = pc + imm;
      NPC_JALR:   target = {aluout[XLEN-1:1], 1'b0};
      default:    target = pc + XLEN'(4);
    endcase
  end

  assign is_trap = (npc_op == NPC_TRAP);
  assign is_mret = (npc_op == NPC_MRET);

  // Alignment only applies to real fetch targets, not trap/return redirects.
  always_comb begin
    misalign = 1'b0;
    if (!is_trap && !is_mret) begin
      if (IALIGN == 32) misalign = |target[1:0];
      else              misalign = target[0];
    end
  end

  assign trap_req = is_trap | misalign | (is_mret & (state == RUN));

  always_comb begin
    state_n = state;
    npc     = target;
    mepc_n  = mepc;
    commit  = 1'b0;
    unique case (state)
      RUN: begin
        if (trap_req) begin
          npc     = TRAP_VEC;
          mepc_n  = pc;
          state_n = HANDLER;
        end else begin
          commit = 1'b1;
        end
      end
      HANDLER: begin
        if (trap_req) begin
          npc     = pc;
          state_n = HALT;
        end else if (is_mret) begin
          npc     = mepc;
          state_n = RUN;
          commit  = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
      default: begin
        npc     = pc;
        state_n = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (!stall) begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      mepc    <= '0;
      retired <= '0;
    end else if (!stall) begin
      pc   <= npc;
      mepc <= mepc_n;
      if (commit) retired <= retired + CNT_W'(1);
    end
  end

  assign in_handler = (state == HANDLER);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomized bench for pc_seq_unit against a behavioural trap/PC model;
// a CNT_W=4 copy shares the inputs to exercise counter wrap.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  npc_op;
  logic [31:0] imm;
  logic [31:0] aluout;
  logic [31:0] pc, npc, mepc;
  logic        misalign, in_handler, halted;
  logic [31:0] retired;
  logic [31:0] pc4, npc4, mepc4;
  logic        mis4, inh4, hlt4;
  logic [3:0]  ret4;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] TV = 32'h100;

  // model: 0=RUN 1=HANDLER 2=HALT
  int          m_st;
  logic [31:0] m_pc;
  logic [31:0] m_mepc;
  logic [31:0] m_ret;

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op),
    .imm(imm), .aluout(aluout), .pc(pc), .npc(npc),
    .mepc(mepc), .misalign(misalign), .in_handler(in_handler),
    .halted(halted), .retired(retired)
  );

  pc_seq_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op),
    .imm(imm), .aluout(aluout), .pc(pc4), .npc(npc4),
    .mepc(mepc4), .misalign(mis4), .in_handler(inh4),
    .halted(hlt4), .retired(ret4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic [31:0] im, input logic [31:0] al);
    logic [31:0] t, e_npc;
    bit mis, trq, mret;
    @(negedge clk);
    rst = r; stall = s; npc_op = op; imm = im; aluout = al;
    #1;
    case (op)
      3'd1, 3'd2: t = m_pc + im;
      3'd4:       t = al & ~32'd1;
      default:    t = m_pc + 32'd4;
    endcase
    mret = (op == 3'd7);
    mis  = (op != 3'd6) && !mret && (t % 4 != 0);
    trq  = (op == 3'd6) || mis || (mret && m_st == 0);
    if (m_st == 2)        e_npc = m_pc;
    else if (trq)         e_npc = (m_st == 0) ? TV : m_pc;
    else if (mret)        e_npc = m_mepc;
    else                  e_npc = t;
    chk("pc", pc, m_pc);
    chk("mepc", mepc, m_mepc);
    chk("retired", retired, m_ret);
    chk("in_handler", 32'(in_handler), 32'(m_st == 1));
    chk("halted", 32'(halted), 32'(m_st == 2));
    chk("npc", npc, e_npc);
    chk("misalign", 32'(misalign), 32'(mis));
    chk("pc_w4", pc4, m_pc);
    chk("retired_w4", 32'(ret4), m_ret % 16);
    @(posedge clk);
    if (r) begin
      m_st = 0; m_pc = 0; m_mepc = 0; m_ret = 0;
    end else if (m_st != 2 && !s) begin
      if (trq) begin
        if (m_st == 0) begin
          m_mepc = m_pc; m_pc = TV; m_st = 1;
        end else begin
          m_st = 2;
        end
      end else begin
        if (mret) m_st = 0;
        m_pc = e_npc;
        m_ret = m_ret + 1;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] ri, ra;
    logic [2:0]  rop;
    rst = 1'b1; stall = 1'b0; npc_op = 3'd0; imm = '0; aluout = '0;
    m_st = 0; m_pc = 0; m_mepc = 0; m_ret = 0;
    @(posedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_ret", retired, 32'd0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("plus4_pc", pc, 32'd12);
    chk("plus4_ret", retired, 32'd3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFF8, 0);
    chk("branch_back", pc, 32'h8);
    step(0, 0, 4, 0, 32'h21);
    chk("jalr_lsb", pc, 32'h20);
    step(0, 0, 2, 32'h6, 0);
    chk("mis_pc", pc, TV);
    chk("mis_mepc", mepc, 32'h20);
    chk("mis_inh", 32'(in_handler), 32'd1);
    chk("mis_ret", retired, 32'd6);
    step(0, 0, 7, 0, 0);
    chk("mret_pc", pc, 32'h20);
    chk("mret_run", 32'(in_handler), 32'd0);
    step(0, 0, 7, 0, 0);
    chk("mret_run_trap", mepc, 32'h20);
    chk("mret_run_pc", pc, TV);
    step(0, 0, 6, 0, 0);
    chk("dbl_halt", 32'(halted), 32'd1);
    step(0, 0, 2, 32'h40, 0);
    step(0, 0, 0, 0, 0);
    chk("halt_pc", pc, TV);
    step(1, 0, 0, 0, 0);
    chk("rst_from_halt", pc, 32'h0);
    repeat (3) step(0, 1, 2, 32'h80, 0);
    chk("stall_pc", pc, 32'h0);
    chk("stall_ret", retired, 32'd0);
    repeat (17) step(0, 0, 0, 0, 0);
    chk("wrap4", 32'(ret4), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rop = 3'd0;
        3:       rop = 3'd1;
        4:       rop = 3'd2;
        5:       rop = 3'd4;
        6:       rop = 3'($urandom_range(0, 7));
        7:       rop = 3'd7;
        8:       rop = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd0;
        default: rop = 3'd1;
      endcase
      ri = ($urandom_range(0, 7) == 0) ? $urandom
           : 32'(($urandom_range(0, 64) - 32) * 4);
      ra = $urandom;
      step(m_st == 2 ? ($urandom_range(0, 5) == 0)
                     : ($urandom_range(0, 200) == 0),
           $urandom_range(0, 7) == 0, rop, ri, ra);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
